// File: rtl/hmac_chunk_verifier.sv
// hmac_chunk_verifier
//
// Receive-side partner of the chunk HMAC tag generator. For every chunk it
// latches the expected tag from upstream, asks the SHA-256 HMAC engine for a
// computation, streams the chunk bursts through to the engine while keeping a
// private copy, and compares the engine's tag with the expected one. A match
// releases the buffered chunk downstream in arrival order; a mismatch drops
// the chunk and raises an authentication error.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (the engine is
//                       reset alongside this block from the same source)
//   tag_in/val/rdy      expected tag for the next chunk (val/rdy)
//   in_data/val/rdy     upstream chunk bursts (val/rdy)
//   out_data/val/last   verified bursts to downstream, last marks final burst
//   out_data_rdy        downstream ready
//   eng_req_val/rdy     request handshake towards the HMAC engine
//   eng_data/val/rdy    bursts forwarded to the engine
//   eng_hmac/val/rdy    computed tag returned by the engine
//   auth_err            one-cycle pulse when a chunk is dropped
//   auth_fail           sticky mismatch flag, cleared by auth_fail_clr
//   fail_count          saturating count of dropped chunks
//   ok_count            wrapping count of released chunks

module hmac_chunk_verifier #(
  parameter int DATA_COUNT_BURSTS = 2,
  parameter int FAIL_CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              tag_in,
  input  logic                      tag_val,
  output logic                      tag_rdy,
  input  logic [511:0]              in_data,
  input  logic                      in_data_val,
  output logic                      in_data_rdy,
  output logic [511:0]              out_data,
  output logic                      out_data_val,
  output logic                      out_data_last,
  input  logic                      out_data_rdy,
  output logic                      eng_req_val,
  input  logic                      eng_req_rdy,
  output logic [511:0]              eng_data,
  output logic                      eng_data_val,
  input  logic                      eng_data_rdy,
  input  logic [127:0]              eng_hmac,
  input  logic                      eng_hmac_val,
  output logic                      eng_hmac_rdy,
  output logic                      auth_err,
  output logic                      auth_fail,
  input  logic                      auth_fail_clr,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count,
  output logic [31:0]               ok_count
);

  localparam int PTR_W = (DATA_COUNT_BURSTS > 1) ? $clog2(DATA_COUNT_BURSTS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FEED,
    WAIT_MAC,
    RELEASE,
    DROP
  } state_t;

  state_t state, state_next;

  logic [127:0]     tag_reg;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [7:0]       burst_cnt;
  logic [511:0]     chunk_buf [DATA_COUNT_BURSTS];

  logic tag_fire;
  logic req_fire;
  logic feed_fire;
  logic mac_fire;
  logic out_fire;
  logic feed_done;
  logic last_out;
  logic mac_match;

  assign tag_fire  = tag_val && tag_rdy;
  assign req_fire  = eng_req_val && eng_req_rdy;
  assign feed_fire = in_data_val && in_data_rdy;
  assign mac_fire  = eng_hmac_val && eng_hmac_rdy;
  assign out_fire  = out_data_val && out_data_rdy;
  // The transfer that takes the counter from 1 to 0 closes the chunk.
  assign feed_done = feed_fire && (burst_cnt == 8'd1);
  assign last_out  = (rd_ptr == PTR_W'(DATA_COUNT_BURSTS - 1));
  assign mac_match = (eng_hmac == tag_reg);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one chunk in flight at a time, back to IDLE after
  // either releasing or dropping it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (tag_fire) state_next = REQ;
      REQ:      if (req_fire) state_next = FEED;
      FEED:     if (feed_done) state_next = WAIT_MAC;
      WAIT_MAC: if (mac_fire) state_next = mac_match ? RELEASE : DROP;
      RELEASE:  if (out_fire && last_out) state_next = IDLE;
      DROP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic. In FEED the upstream and engine data interfaces are wired
  // straight through so the engine sets the pace; everywhere else the data
  // paths are closed and outputs sit at zero.
  always_comb begin
    tag_rdy       = 1'b0;
    in_data_rdy   = 1'b0;
    out_data      = '0;
    out_data_val  = 1'b0;
    out_data_last = 1'b0;
    eng_req_val   = 1'b0;
    eng_data      = '0;
    eng_data_val  = 1'b0;
    eng_hmac_rdy  = 1'b0;
    auth_err      = 1'b0;
    case (state)
      IDLE:     tag_rdy = 1'b1;
      REQ:      eng_req_val = 1'b1;
      FEED: begin
        eng_data     = in_data;
        eng_data_val = in_data_val;
        in_data_rdy  = eng_data_rdy;
      end
      WAIT_MAC: eng_hmac_rdy = 1'b1;
      RELEASE: begin
        out_data      = chunk_buf[rd_ptr];
        out_data_val  = 1'b1;
        out_data_last = last_out;
      end
      DROP:     auth_err = 1'b1;
      default:  ;
    endcase
  end

  // Control datapath: expected tag, buffer pointers, burst counter and the
  // status counters. auth_fail set in DROP takes priority over a clear
  // arriving in the same cycle so no failure is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      burst_cnt  <= '0;
      fail_count <= '0;
      ok_count   <= '0;
      auth_fail  <= 1'b0;
    end else begin
      if (tag_fire) begin
        tag_reg <= tag_in;
      end
      if (state == REQ && req_fire) begin
        burst_cnt <= 8'(DATA_COUNT_BURSTS);
        wr_ptr    <= '0;
      end
      if (state == FEED && feed_fire) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        burst_cnt <= burst_cnt - 8'd1;
      end
      if (state == WAIT_MAC && mac_fire && mac_match) begin
        rd_ptr <= '0;
      end
      if (state == RELEASE && out_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (last_out) begin
          ok_count <= ok_count + 32'd1;
        end
      end
      if (state == DROP) begin
        auth_fail <= 1'b1;
        if (fail_count != '1) begin
          fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
        end
      end else if (auth_fail_clr) begin
        auth_fail <= 1'b0;
      end
    end
  end

  // Chunk buffer. Contents only matter between FEED and RELEASE, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (state == FEED && feed_fire) begin
      chunk_buf[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_hmac_chunk_verifier.sv
// tb_hmac_chunk_verifier
//
// Directed bench for hmac_chunk_verifier with two bursts per chunk and a
// 2-bit failure counter so saturation is reachable. A small engine stand-in
// is driven from the stimulus tasks; a monitor logs every burst that reaches
// the engine and every burst released downstream.

module tb_hmac_chunk_verifier;

  localparam int N_BURSTS = 2;
  localparam int FCW      = 2;
  localparam logic [127:0] TAG_A = {16{8'hA5}};
  localparam logic [127:0] TAG_B = {16{8'h3C}};

  logic           clk;
  logic           rst;
  logic [127:0]   tag_in;
  logic           tag_val;
  logic           tag_rdy;
  logic [511:0]   in_data;
  logic           in_data_val;
  logic           in_data_rdy;
  logic [511:0]   out_data;
  logic           out_data_val;
  logic           out_data_last;
  logic           out_data_rdy;
  logic           eng_req_val;
  logic           eng_req_rdy;
  logic [511:0]   eng_data;
  logic           eng_data_val;
  logic           eng_data_rdy;
  logic [127:0]   eng_hmac;
  logic           eng_hmac_val;
  logic           eng_hmac_rdy;
  logic           auth_err;
  logic           auth_fail;
  logic           auth_fail_clr;
  logic [FCW-1:0] fail_count;
  logic [31:0]    ok_count;

  logic           toggle_mode;
  logic           phase;

  logic [511:0]   eng_log[$];
  logic [511:0]   out_log[$];
  logic           last_log[$];
  int             err_cnt;

  int             vectors;
  int             miscompares;

  hmac_chunk_verifier #(
    .DATA_COUNT_BURSTS(N_BURSTS),
    .FAIL_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tag_in(tag_in),
    .tag_val(tag_val),
    .tag_rdy(tag_rdy),
    .in_data(in_data),
    .in_data_val(in_data_val),
    .in_data_rdy(in_data_rdy),
    .out_data(out_data),
    .out_data_val(out_data_val),
    .out_data_last(out_data_last),
    .out_data_rdy(out_data_rdy),
    .eng_req_val(eng_req_val),
    .eng_req_rdy(eng_req_rdy),
    .eng_data(eng_data),
    .eng_data_val(eng_data_val),
    .eng_data_rdy(eng_data_rdy),
    .eng_hmac(eng_hmac),
    .eng_hmac_val(eng_hmac_val),
    .eng_hmac_rdy(eng_hmac_rdy),
    .auth_err(auth_err),
    .auth_fail(auth_fail),
    .auth_fail_clr(auth_fail_clr),
    .fail_count(fail_count),
    .ok_count(ok_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine data ready either sits high or alternates every cycle.
  assign eng_data_rdy = toggle_mode ? phase : 1'b1;

  // Monitor: record completed transfers and auth_err pulses at each edge.
  always @(posedge clk) begin
    phase <= ~phase;
    if (eng_data_val && eng_data_rdy) eng_log.push_back(eng_data);
    if (out_data_val && out_data_rdy) begin
      out_log.push_back(out_data);
      last_log.push_back(out_data_last);
    end
    if (auth_err) err_cnt++;
  end

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    eng_log.delete();
    out_log.delete();
    last_log.delete();
    err_cnt = 0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic sendTag(input logic [127:0] t);
    int n;
    tag_in  = t;
    tag_val = 1'b1;
    #1;
    n = 0;
    while (!tag_rdy && n < 50) begin
      step();
      n++;
    end
    checkOutput("tag_rdy_wait", 512'(tag_rdy), 512'(1));
    step();
    tag_val = 1'b0;
  endtask

  task automatic sendBurst(input logic [511:0] b, input int gap);
    int n;
    in_data     = b;
    in_data_val = 1'b1;
    #1;
    n = 0;
    while (!in_data_rdy && n < 50) begin
      step();
      n++;
    end
    checkOutput("in_rdy_wait", 512'(in_data_rdy), 512'(1));
    step();
    in_data_val = 1'b0;
    repeat (gap) step();
  endtask

  task automatic returnMac(input logic [127:0] m);
    int n;
    eng_hmac     = m;
    eng_hmac_val = 1'b1;
    #1;
    n = 0;
    while (!eng_hmac_rdy && n < 50) begin
      step();
      n++;
    end
    checkOutput("hmac_rdy_wait", 512'(eng_hmac_rdy), 512'(1));
    step();
    eng_hmac_val = 1'b0;
  endtask

  // One full chunk: tag, two bursts, engine answer. Returns one cycle after
  // the engine tag handshake, i.e. where release or drop must be visible.
  task automatic applyStimulus(input logic [127:0] t, input logic [511:0] b0,
                               input logic [511:0] b1, input logic [127:0] m, input int gap);
    sendTag(t);
    sendBurst(b0, gap);
    sendBurst(b1, gap);
    returnMac(m);
  endtask

  task automatic drain();
    out_data_rdy = 1'b1;
    repeat (4) step();
  endtask

  logic [511:0] held_data;
  logic         held_last;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    phase         = 1'b0;
    toggle_mode   = 1'b0;
    rst           = 1'b1;
    tag_in        = '0;
    tag_val       = 1'b0;
    in_data       = '0;
    in_data_val   = 1'b0;
    out_data_rdy  = 1'b1;
    eng_req_rdy   = 1'b1;
    eng_hmac      = '0;
    eng_hmac_val  = 1'b0;
    auth_fail_clr = 1'b0;
    clearLogs();

    // Reset state.
    applyReset();
    checkOutput("rst_tag_rdy", 512'(tag_rdy), 512'(1));
    checkOutput("rst_out_val", 512'(out_data_val), 512'(0));
    checkOutput("rst_req_val", 512'(eng_req_val), 512'(0));
    checkOutput("rst_in_rdy", 512'(in_data_rdy), 512'(0));
    checkOutput("rst_auth_err", 512'(auth_err), 512'(0));
    checkOutput("rst_auth_fail", 512'(auth_fail), 512'(0));
    checkOutput("rst_fail_cnt", 512'(fail_count), 512'(0));
    checkOutput("rst_ok_cnt", 512'(ok_count), 512'(0));

    // Matching chunk, also checking tag -> request latency.
    clearLogs();
    sendTag(TAG_A);
    checkOutput("m_req_latency", 512'(eng_req_val), 512'(1));
    sendBurst(512'h1, 0);
    sendBurst(512'h2, 0);
    returnMac(TAG_A);
    checkOutput("m_out_latency", 512'(out_data_val), 512'(1));
    drain();
    checkOutput("m_eng_len", 512'(eng_log.size()), 512'(2));
    checkOutput("m_eng0", eng_log[0], 512'h1);
    checkOutput("m_eng1", eng_log[1], 512'h2);
    checkOutput("m_out_len", 512'(out_log.size()), 512'(2));
    checkOutput("m_out0", out_log[0], 512'h1);
    checkOutput("m_out1", out_log[1], 512'h2);
    checkOutput("m_last0", 512'(last_log[0]), 512'(0));
    checkOutput("m_last1", 512'(last_log[1]), 512'(1));
    checkOutput("m_ok_cnt", 512'(ok_count), 512'(1));
    checkOutput("m_err_cnt", 512'(err_cnt), 512'(0));
    checkOutput("m_auth_fail", 512'(auth_fail), 512'(0));

    // Mismatching chunk.
    clearLogs();
    applyStimulus(TAG_A, 512'h1, 512'h2, TAG_A ^ 128'h1, 0);
    checkOutput("x_err_latency", 512'(auth_err), 512'(1));
    checkOutput("x_out_val", 512'(out_data_val), 512'(0));
    step();
    checkOutput("x_err_pulse", 512'(auth_err), 512'(0));
    drain();
    checkOutput("x_err_cnt", 512'(err_cnt), 512'(1));
    checkOutput("x_out_len", 512'(out_log.size()), 512'(0));
    checkOutput("x_auth_fail", 512'(auth_fail), 512'(1));
    checkOutput("x_fail_cnt", 512'(fail_count), 512'(1));
    checkOutput("x_ok_cnt", 512'(ok_count), 512'(1));

    // Following matching chunk leaves the sticky flag alone.
    clearLogs();
    applyStimulus(TAG_B, 512'h11, 512'h22, TAG_B, 0);
    drain();
    checkOutput("f_out_len", 512'(out_log.size()), 512'(2));
    checkOutput("f_out1", out_log[1], 512'h22);
    checkOutput("f_ok_cnt", 512'(ok_count), 512'(2));
    checkOutput("f_auth_fail", 512'(auth_fail), 512'(1));
    auth_fail_clr = 1'b1;
    step();
    auth_fail_clr = 1'b0;
    checkOutput("f_auth_clr", 512'(auth_fail), 512'(0));

    // Backpressure on both the engine and downstream sides.
    clearLogs();
    toggle_mode  = 1'b1;
    out_data_rdy = 1'b0;
    applyStimulus(TAG_A, 512'hDEAD, 512'hBEEF, TAG_A, 3);
    held_data = out_data;
    held_last = out_data_last;
    checkOutput("b_hold_data0", held_data, 512'hDEAD);
    checkOutput("b_hold_last0", 512'(held_last), 512'(0));
    repeat (5) step();
    checkOutput("b_hold_val", 512'(out_data_val), 512'(1));
    checkOutput("b_hold_data", out_data, 512'hDEAD);
    checkOutput("b_hold_last", 512'(out_data_last), 512'(0));
    checkOutput("b_hold_none", 512'(out_log.size()), 512'(0));
    drain();
    toggle_mode = 1'b0;
    checkOutput("b_eng_len", 512'(eng_log.size()), 512'(2));
    checkOutput("b_eng0", eng_log[0], 512'hDEAD);
    checkOutput("b_eng1", eng_log[1], 512'hBEEF);
    checkOutput("b_out0", out_log[0], 512'hDEAD);
    checkOutput("b_out1", out_log[1], 512'hBEEF);
    checkOutput("b_last1", 512'(last_log[1]), 512'(1));
    checkOutput("b_ok_cnt", 512'(ok_count), 512'(3));

    // Early upstream data is held off until the engine request completes.
    clearLogs();
    eng_req_rdy = 1'b0;
    in_data     = 512'h77;
    in_data_val = 1'b1;
    step();
    checkOutput("e_idle_rdy", 512'(in_data_rdy), 512'(0));
    sendTag(TAG_B);
    checkOutput("e_req_val", 512'(eng_req_val), 512'(1));
    checkOutput("e_req_rdy0", 512'(in_data_rdy), 512'(0));
    step();
    checkOutput("e_req_rdy1", 512'(in_data_rdy), 512'(0));
    checkOutput("e_eng_none", 512'(eng_log.size()), 512'(0));
    eng_req_rdy = 1'b1;
    step();
    sendBurst(512'h77, 0);
    sendBurst(512'h88, 0);
    returnMac(TAG_B);
    drain();
    checkOutput("e_eng_len", 512'(eng_log.size()), 512'(2));
    checkOutput("e_eng0", eng_log[0], 512'h77);
    checkOutput("e_out1", out_log[1], 512'h88);
    checkOutput("e_ok_cnt", 512'(ok_count), 512'(4));

    // Reset after one burst of a chunk aborts it.
    clearLogs();
    sendTag(TAG_A);
    sendBurst(512'h5, 0);
    applyReset();
    checkOutput("r_tag_rdy", 512'(tag_rdy), 512'(1));
    checkOutput("r_out_val", 512'(out_data_val), 512'(0));
    checkOutput("r_ok_cnt", 512'(ok_count), 512'(0));
    checkOutput("r_fail_cnt", 512'(fail_count), 512'(0));
    repeat (3) step();
    checkOutput("r_out_none", 512'(out_log.size()), 512'(0));
    clearLogs();
    applyStimulus(TAG_A, 512'h1, 512'h2, TAG_A, 0);
    drain();
    checkOutput("r_next_out0", out_log[0], 512'h1);
    checkOutput("r_next_ok", 512'(ok_count), 512'(1));

    // Saturating failure counter.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(TAG_B, 512'h9, 512'hA, TAG_B ^ 128'h80, 0);
      drain();
      if (i == 2) checkOutput("s_fail_cnt3", 512'(fail_count), 512'(3));
    end
    checkOutput("s_fail_sat", 512'(fail_count), 512'(3));
    checkOutput("s_auth_fail", 512'(auth_fail), 512'(1));
    checkOutput("s_ok_cnt", 512'(ok_count), 512'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
